// File: rtl/dmem_rmw_ctrl_pkg.sv
// Shared encodings for the data-memory read-modify-write controller.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package dmem_rmw_ctrl_pkg;

    // Access codes carried on req_access; any other value is a no-op.
    localparam logic [3:0] LD_B  = 4'h0;
    localparam logic [3:0] LD_H  = 4'h1;
    localparam logic [3:0] LD_W  = 4'h2;
    localparam logic [3:0] LD_BU = 4'h4;
    localparam logic [3:0] LD_HU = 4'h5;
    localparam logic [3:0] ST_B  = 4'h8;
    localparam logic [3:0] ST_H  = 4'h9;
    localparam logic [3:0] ST_W  = 4'hA;

    // Controller state encoding.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_MERGE = 3'd2,
        S_WR    = 3'd3,
        S_RESP  = 3'd4
    } dmem_rmw_state_e;

    function automatic logic is_load(input logic [3:0] access);
        return (access == LD_B) || (access == LD_H) || (access == LD_W) ||
               (access == LD_BU) || (access == LD_HU);
    endfunction

    function automatic logic is_store(input logic [3:0] access);
        return (access == ST_B) || (access == ST_H) || (access == ST_W);
    endfunction

    function automatic logic is_mem_access(input logic [3:0] access);
        return is_load(access) || is_store(access);
    endfunction

endpackage

// File: rtl/dmem_lane_mux.sv
// Byte/half lane extraction for loads, lane merge for stores, alignment check.
// Latency: purely combinational.
// Backpressure: none; the controller decides when outputs are used.
module dmem_lane_mux
    import dmem_rmw_ctrl_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [3:0]  access,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged,
    output logic        misalign
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Pick the addressed byte and half out of the RAM word.
    always_comb begin
        byte_lane = word[{addr, 3'b000} +: 8];
        half_lane = addr[1] ? word[31:16] : word[15:0];
    end

    // Per-access extension, merge and alignment rules; no-op codes yield zeros.
    always_comb begin
        load_val = '0;
        merged   = word;
        misalign = 1'b0;
        case (access)
            LD_B:  load_val = {{24{byte_lane[7]}}, byte_lane};
            LD_BU: load_val = {24'h0, byte_lane};
            LD_H: begin
                misalign = addr[0];
                load_val = {{16{half_lane[15]}}, half_lane};
            end
            LD_HU: begin
                misalign = addr[0];
                load_val = {16'h0, half_lane};
            end
            LD_W: begin
                misalign = (addr != 2'b00);
                load_val = word;
            end
            ST_B:  merged[{addr, 3'b000} +: 8] = wdata[7:0];
            ST_H: begin
                misalign = addr[0];
                merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
            end
            ST_W: begin
                misalign = (addr != 2'b00);
                merged   = wdata;
            end
            default: begin
                load_val = '0;
                merged   = word;
                misalign = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_rmw_ctrl.sv
// Load/store responder for a single-port sync-read RAM with sub-word read-modify-write.
// Latency: accept to resp_valid = 3 cycles load, 4 store, 1 misaligned/no-op.
// Backpressure: one request in flight; req_ready only in IDLE, response held until resp_ready.
module dmem_rmw_ctrl
    import dmem_rmw_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [3:0]        req_access,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    dmem_rmw_state_e state;
    dmem_rmw_state_e state_nxt;

    logic [ADDR_W+1:0] addr_q;
    logic [3:0]        access_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merged_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              accept;
    logic [1:0]        lane_addr;
    logic [3:0]        lane_access;
    logic [31:0]       lane_load;
    logic [31:0]       lane_merged;
    logic              lane_misalign;

    // Byte address bits above the RAM's reach are deliberately dropped.
    logic              unused_req_addr_hi;
    assign unused_req_addr_hi = ^req_addr[31:ADDR_W+2];

    assign accept = (state == S_IDLE) && req_valid;

    // In IDLE the mux judges the incoming request's alignment; later it works on the held request.
    always_comb begin
        lane_addr   = addr_q[1:0];
        lane_access = access_q;
        if (state == S_IDLE) begin
            lane_addr   = req_addr[1:0];
            lane_access = req_access;
        end
    end

    dmem_lane_mux u_lane_mux (
        .addr     (lane_addr),
        .access   (lane_access),
        .word     (mem_rdata),
        .wdata    (wdata_q),
        .load_val (lane_load),
        .merged   (lane_merged),
        .misalign (lane_misalign)
    );

    // State register; reset aborts any operation in flight and drops its response.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: bad or no-op requests skip the RAM entirely, only stores visit WR.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (lane_misalign || !is_mem_access(req_access)) begin
                        state_nxt = S_RESP;
                    end else begin
                        state_nxt = S_RD;
                    end
                end
            end
            S_RD:    state_nxt = S_MERGE;
            S_MERGE: state_nxt = is_store(access_q) ? S_WR : S_RESP;
            S_WR:    state_nxt = S_RESP;
            S_RESP: begin
                if (resp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request capture on accept; load result or merged store word captured in MERGE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q   <= '0;
            access_q <= '0;
            wdata_q  <= '0;
            merged_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            addr_q   <= req_addr[ADDR_W+1:0];
            access_q <= req_access;
            wdata_q  <= req_wdata;
            rdata_q  <= '0;
            err_q    <= lane_misalign;
        end else if (state == S_MERGE) begin
            if (is_store(access_q)) begin
                merged_q <= lane_merged;
            end else begin
                rdata_q  <= lane_load;
            end
        end
    end

    // The RAM address stays on the held request from RD through WR.
    assign mem_addr   = addr_q[ADDR_W+1:2];
    assign mem_we     = (state == S_WR);
    assign mem_wdata  = merged_q;
    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Directed checks of dmem_rmw_ctrl against a behavioural sync-read RAM.
// Latency: measured per request from the accept edge to first resp_valid.
// Backpressure: resp_ready driven by the bench, including a held-low window.
module tb_dmem_rmw_ctrl;
    import dmem_rmw_ctrl_pkg::*;

    localparam int ADDR_W = 10;

    logic              clk;
    logic              rstn;
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic [3:0]        req_access;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic [31:0]       ram [0:(1<<ADDR_W)-1];
    logic              preloaded;
    int                we_cnt;
    logic [31:0]       last_wdata;
    logic [ADDR_W-1:0] last_waddr;

    int n_checks;
    int n_err;

    dmem_rmw_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_access (req_access),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sync-read RAM, one-time preload, and a log of every write pulse.
    initial begin
        preloaded = 1'b0;
        we_cnt    = 0;
    end
    always @(posedge clk) begin
        if (!preloaded) begin
            ram[10'h040] <= 32'h8899AABB;
            ram[10'h041] <= 32'h01020304;
            preloaded    <= 1'b1;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            we_cnt        <= we_cnt + 1;
            last_wdata    <= mem_wdata;
            last_waddr    <= mem_addr;
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one request, return cycles from accept edge to first resp_valid.
    task automatic send(input logic [31:0] a, input logic [3:0] acc, input logic [31:0] wd,
                        output int lat);
        @(negedge clk);
        req_valid  = 1'b1;
        req_addr   = a;
        req_access = acc;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 16) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    // Full transaction: check latency, data and error, then complete the response.
    task automatic run(input string tag, input logic [31:0] a, input logic [3:0] acc,
                       input logic [31:0] wd, input logic [31:0] exp_rdata,
                       input logic exp_err, input int exp_lat);
        int lat;
        send(a, acc, wd, lat);
        check({tag, ".lat"}, lat, exp_lat);
        check({tag, ".rdata"}, resp_rdata, exp_rdata);
        check({tag, ".err"}, {31'h0, resp_err}, {31'h0, exp_err});
        handshake();
        check({tag, ".idle"}, {31'h0, req_ready}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int we0;
        int lat;
        n_checks   = 0;
        n_err      = 0;
        rstn       = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_access = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst.req_ready",  {31'h0, req_ready},  32'h1);
        check("rst.resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst.resp_rdata", resp_rdata,          32'h0);
        check("rst.resp_err",   {31'h0, resp_err},   32'h0);
        check("rst.mem_we",     {31'h0, mem_we},     32'h0);
        check("rst.mem_addr",   {22'h0, mem_addr},   32'h0);
        check("rst.mem_wdata",  mem_wdata,           32'h0);
        @(negedge clk);
        rstn = 1'b1;

        // Loads from word 0x40 = 0x8899AABB.
        run("ld_b_101",  32'h101, LD_B,  32'h0, 32'hFFFFFFAA, 1'b0, 3);
        run("ld_hu_102", 32'h102, LD_HU, 32'h0, 32'h00008899, 1'b0, 3);
        run("ld_h_102",  32'h102, LD_H,  32'h0, 32'hFFFF8899, 1'b0, 3);
        run("ld_bu_100", 32'h100, LD_BU, 32'h0, 32'h000000BB, 1'b0, 3);
        run("ld_h_100",  32'h100, LD_H,  32'h0, 32'hFFFFAABB, 1'b0, 3);
        check("loads.no_we", we_cnt, 0);

        // Byte store into lane 3, then read back.
        we0 = we_cnt;
        run("st_b_103", 32'h103, ST_B, 32'h12345612, 32'h0, 1'b0, 4);
        check("st_b_103.we_pulses", we_cnt - we0, 1);
        check("st_b_103.wdata", last_wdata, 32'h1299AABB);
        check("st_b_103.waddr", {22'h0, last_waddr}, 32'h40);
        run("ld_w_100", 32'h100, LD_W, 32'h0, 32'h1299AABB, 1'b0, 3);

        // Misaligned and no-op requests never touch the RAM.
        we0 = we_cnt;
        run("ld_w_102_mis", 32'h102, LD_W, 32'h0, 32'h0, 1'b1, 1);
        run("st_h_101_mis", 32'h101, ST_H, 32'h0000BEEF, 32'h0, 1'b1, 1);
        run("noop", 32'h100, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b0, 1);
        check("mis.no_we", we_cnt - we0, 0);
        check("mis.word_40", ram[10'h040], 32'h1299AABB);

        // Half store into upper lane, then read back.
        we0 = we_cnt;
        run("st_h_102", 32'h102, ST_H, 32'h0000BEEF, 32'h0, 1'b0, 4);
        check("st_h_102.wdata", last_wdata, 32'hBEEFAABB);
        run("ld_w_100b", 32'h100, LD_W, 32'h0, 32'hBEEFAABB, 1'b0, 3);

        // Response held under backpressure while a competing request waits.
        send(32'h100, LD_B, 32'h0, lat);
        check("bp.lat", lat, 3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid  = 1'b1;
            req_addr   = 32'h104;
            req_access = LD_W;
            @(posedge clk);
            #1;
            check("bp.resp_valid", {31'h0, resp_valid}, 32'h1);
            check("bp.rdata", resp_rdata, 32'hFFFFFFBB);
            check("bp.err", {31'h0, resp_err}, 32'h0);
            check("bp.req_ready", {31'h0, req_ready}, 32'h0);
        end
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check("bp.after_req_ready", {31'h0, req_ready}, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        check("bp.nothing_pending", {31'h0, resp_valid}, 32'h0);

        // Reset during MERGE of a word store.
        we0 = we_cnt;
        @(negedge clk);
        req_valid  = 1'b1;
        req_addr   = 32'h104;
        req_access = ST_W;
        req_wdata  = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("mid_rst.req_ready",  {31'h0, req_ready},  32'h1);
        check("mid_rst.resp_valid", {31'h0, resp_valid}, 32'h0);
        check("mid_rst.resp_rdata", resp_rdata,          32'h0);
        check("mid_rst.resp_err",   {31'h0, resp_err},   32'h0);
        check("mid_rst.mem_we",     {31'h0, mem_we},     32'h0);
        check("mid_rst.mem_addr",   {22'h0, mem_addr},   32'h0);
        check("mid_rst.mem_wdata",  mem_wdata,           32'h0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst.no_we", we_cnt - we0, 0);
        check("mid_rst.word_41", ram[10'h041], 32'h01020304);
        check("mid_rst.no_resp", {31'h0, resp_valid}, 32'h0);
        run("ld_w_104", 32'h104, LD_W, 32'h0, 32'h01020304, 1'b0, 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_rmw_ctrl.md
Name: dmem_rmw_ctrl

Overview:
- Memory-side responder for the CPU's load/store path.
- Accepts byte/half/word load and store requests with a valid/ready handshake.
- Drives a single-port, synchronous-read 32-bit data RAM.
- Performs lane extraction with sign/zero extension for loads, and read-modify-write merging for sub-word stores.
- Returns one response per request; misaligned accesses are flagged and never write memory.

Parameters:
- ADDR_W, 10, word-address width of the attached RAM. Byte address bits [ADDR_W+1:2] select the word; higher bits are ignored.

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rstn  in  1  reset; asynchronous assert, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_addr  in  32  byte address
- req_access  in  4  access code: LD_B, LD_H, LD_W, LD_BU, LD_HU, ST_B, ST_H, ST_W, or any other code = no-op
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  response present
- resp_ready  in  1  requester accepts the response
- resp_rdata  out  32  load result, extended; 0 for stores, no-ops and errors
- resp_err  out  1  misaligned access
- mem_addr  out  ADDR_W  RAM word address
- mem_we  out  1  RAM write enable
- mem_wdata  out  32  RAM write data (full word)
- mem_rdata  in  32  RAM read data, valid the cycle after mem_addr is presented with mem_we=0

Behaviour:
- Reset values, and values while rstn=0: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wdata=0.
- States: IDLE, RD, MERGE, WR, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, register addr, access and wdata, then choose the next state:
    - Misaligned access (LD_H, LD_HU or ST_H with addr[0]=1; LD_W or ST_W with addr[1:0]!=0): go to RESP with err=1, rdata=0.
    - No-op code: go to RESP with err=0, rdata=0.
    - Otherwise: go to RD.
- RD:
  - mem_addr = registered addr[ADDR_W+1:2], mem_we=0.
  - Next state MERGE.
- MERGE: capture mem_rdata.
  - Load: form resp_rdata, then go to RESP.
    - B: byte at lane addr[1:0], sign-extended.
    - BU: same byte, zero-extended.
    - H / HU: half at lane addr[1], sign- or zero-extended.
    - W: full word.
  - Store: form the merged word, then go to WR.
    - B: replace byte lane addr[1:0] with wdata[7:0].
    - H: replace half lane addr[1] with wdata[15:0].
    - W: wdata.
- WR:
  - mem_we=1 for exactly this cycle, with mem_addr unchanged and mem_wdata = merged word.
  - Next state RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err held stable; req_ready=0.
  - On resp_ready, go to IDLE.
- Latency from accept edge to first resp_valid cycle: load 3 cycles, store 4, error/no-op 1.
- Throughput: at most one outstanding request; no new accept in the cycle resp handshake completes (req_ready only in IDLE).
- mem_we is asserted only in WR, never for loads, errors or no-ops.
- Reset mid-operation: an abort before WR leaves the RAM untouched; the pending response is discarded.
- req_* are ignored outside IDLE.

Decomposition:
- Shared header/package: access encodings (LD_*, ST_*, no-op) already live in dmem_type.vh; add the FSM state encoding there as dmem_rmw_state constants.
- One combinational sub-module: dmem_lane_mux.
  - Inputs: addr[1:0], access, word, wdata.
  - Outputs: extracted/extended load value, merged store word, misalign flag.
  - Keeps datapath separate from the FSM.

Test Plan:
- Preload word 0x40 = 0x8899AABB. LD_B addr 0x101 -> resp_rdata=0xFFFFFFAA, err=0, response 3 cycles after accept, mem_we never high.
- Same word. LD_HU addr 0x102 -> 0x00008899; LD_H addr 0x102 -> 0xFFFF8899; LD_BU addr 0x100 -> 0x000000BB.
- ST_B addr 0x103 wdata 0x12345612 -> single mem_we pulse with mem_wdata=0x1299AABB; then LD_W 0x100 -> 0x1299AABB.
- Misalignment: LD_W addr 0x102 -> rdata=0, err=1, 1-cycle latency. ST_H addr 0x101 wdata 0xBEEF -> err=1, mem_we stays 0, word unchanged.
- Backpressure: resp_ready held low 5 cycles after a load -> resp_valid, rdata and err stable, req_ready=0, a new req_valid is ignored until the handshake completes.
- Reset mid-store: rstn low during MERGE of ST_W 0x104 wdata 0xDEADBEEF -> no mem_we pulse, all outputs at reset values, word 0x41 unchanged, next request processed normally.
